// File: rtl/oclib_uart_tx_cfg.sv
// oclib_uart_tx_cfg: UART transmitter with character FIFO and runtime
// framing: 5-8 data bits, none/even/odd/mark parity, 1-2 stops, break.
module oclib_uart_tx_cfg #(
  parameter int FifoDepth    = 32,
  parameter int DivW         = 16,
  parameter int ResetDivisor = 868
) (
  input  logic            clock,
  input  logic            resetN,
  input  logic [7:0]      txData,
  input  logic            txValid,
  output logic            txReady,
  input  logic [DivW-1:0] cfgDivisor,
  input  logic [1:0]      cfgDataBits,
  input  logic [1:0]      cfgParity,
  input  logic            cfgStopBits,
  input  logic            breakReq,
  output logic            busy,
  output logic            tx
);

  localparam int AW = $clog2(FifoDepth);
  localparam logic [AW:0]     POne = (AW+1)'(1);
  localparam logic [DivW-1:0] DOne = DivW'(1);
  localparam logic [DivW-1:0] DTwo = DivW'(2);

  typedef enum logic [2:0] {
    StIdle, StStart, StData,
    StParity, StStop, StBreak
  } state_t;

  // character FIFO (Width 8, Depth FifoDepth)
  logic [7:0]  r_fifoMem [FifoDepth];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_fifoUp;
  logic        w_fifoFull;
  logic        w_fifoInReady;
  logic        w_fifoPush;
  logic        w_fifoOutValid;
  logic [7:0]  w_fifoOutData;
  logic        w_fifoPop;

  // transmitter
  state_t          r_state;
  state_t          w_stateN;
  logic            r_tx;
  logic            w_txN;
  logic [DivW-1:0] r_cnt;
  logic [DivW-1:0] w_cntN;
  logic [2:0]      r_bit;
  logic [2:0]      w_bitN;
  logic            r_stopLeft;
  logic            w_stopLeftN;
  logic            r_pop;
  logic            w_popN;
  logic            w_load;

  logic [DivW-1:0] r_div;
  logic [1:0]      r_nbits;
  logic [1:0]      r_par;
  logic            r_stop2;
  logic [7:0]      r_data;

  logic [DivW-1:0] w_divEff;
  logic [DivW-1:0] w_divIn;
  logic            w_last;
  logic            w_lastBit;
  logic [2:0]      w_nextBit;
  logic [7:0]      w_mask;
  logic            w_parity;
  logic            w_parBit;

  assign w_fifoFull =
    (r_wptr[AW] != r_rptr[AW]) &&
    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_fifoInReady  = r_fifoUp && !w_fifoFull;
  assign w_fifoOutValid = r_wptr != r_rptr;
  assign w_fifoOutData  = r_fifoMem[r_rptr[AW-1:0]];
  assign w_fifoPush     = txValid && w_fifoInReady;
  assign w_fifoPop      = r_pop && w_fifoOutValid;

  // FIFO pointers; ready rises one cycle after reset release
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fifoUp <= 1'b0;
    end else begin
      r_fifoUp <= 1'b1;
      if (w_fifoPush) r_wptr <= r_wptr + POne;
      if (w_fifoPop)  r_rptr <= r_rptr + POne;
    end
  end

  // FIFO storage, contents are don't-care until written
  always_ff @(posedge clock) begin
    if (w_fifoPush) r_fifoMem[r_wptr[AW-1:0]] <= txData;
  end

  assign w_divIn   = (cfgDivisor < DTwo) ? DTwo : cfgDivisor;
  assign w_divEff  = (r_div < DTwo) ? DTwo : r_div;
  assign w_last    = (r_cnt == '0);
  assign w_lastBit = (r_bit == {1'b1, r_nbits});
  assign w_nextBit = r_bit + 3'd1;
  assign w_mask    = 8'hFF >> (2'd3 - r_nbits);
  assign w_parity  = ^(r_data & w_mask);
  assign w_parBit  = (r_par == 2'd3) |
                     (w_parity ^ (r_par == 2'd2));

  // next-state and next-line-value logic
  always_comb begin
    w_stateN    = r_state;
    w_txN       = r_tx;
    w_cntN      = r_cnt;
    w_bitN      = r_bit;
    w_stopLeftN = r_stopLeft;
    w_popN      = 1'b0;
    w_load      = 1'b0;
    if (!w_last) w_cntN = r_cnt - DOne;
    unique case (r_state)
      StIdle: begin
        w_txN  = 1'b1;
        w_cntN = '0;
        if (breakReq) begin
          w_stateN = StBreak;
          w_txN    = 1'b0;
          w_load   = 1'b1;
        end else if (w_fifoOutValid) begin
          w_stateN = StStart;
          w_txN    = 1'b0;
          w_load   = 1'b1;
          w_bitN   = '0;
          w_cntN   = w_divIn - DOne;
        end
      end
      StStart: begin
        if (w_last) begin
          w_stateN = StData;
          w_txN    = r_data[0];
          w_bitN   = '0;
          w_cntN   = w_divEff - DOne;
        end
      end
      StData: begin
        if (w_last) begin
          w_cntN = w_divEff - DOne;
          if (!w_lastBit) begin
            w_bitN = w_nextBit;
            w_txN  = r_data[w_nextBit];
          end else if (r_par != 2'd0) begin
            w_stateN = StParity;
            w_txN    = w_parBit;
          end else begin
            w_stateN    = StStop;
            w_txN       = 1'b1;
            w_popN      = 1'b1;
            w_stopLeftN = r_stop2;
          end
        end
      end
      StParity: begin
        if (w_last) begin
          w_stateN    = StStop;
          w_txN       = 1'b1;
          w_popN      = 1'b1;
          w_stopLeftN = r_stop2;
          w_cntN      = w_divEff - DOne;
        end
      end
      StStop: begin
        w_txN = 1'b1;
        if (w_last) begin
          if (r_stopLeft) begin
            w_stopLeftN = 1'b0;
            w_cntN      = w_divEff - DOne;
          end else if (w_fifoOutValid && !breakReq) begin
            w_stateN = StStart;
            w_txN    = 1'b0;
            w_load   = 1'b1;
            w_bitN   = '0;
            w_cntN   = w_divIn - DOne;
          end else begin
            w_stateN = StIdle;
          end
        end
      end
      StBreak: begin
        w_txN  = 1'b0;
        w_cntN = '0;
        if (!breakReq) begin
          w_stateN    = StStop;
          w_txN       = 1'b1;
          w_stopLeftN = 1'b0;
          w_cntN      = w_divEff - DOne;
        end
      end
      default: begin
        w_stateN = StIdle;
        w_txN    = 1'b1;
      end
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= StIdle;
    else         r_state <= w_stateN;
  end

  // line, bit counters and per-character configuration
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_tx       <= 1'b1;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_stopLeft <= 1'b0;
      r_pop      <= 1'b0;
      r_div      <= DivW'(ResetDivisor);
      r_nbits    <= 2'd3;
      r_par      <= 2'd0;
      r_stop2    <= 1'b0;
      r_data     <= '0;
    end else begin
      r_tx       <= w_txN;
      r_cnt      <= w_cntN;
      r_bit      <= w_bitN;
      r_stopLeft <= w_stopLeftN;
      r_pop      <= w_popN;
      if (w_load) begin
        r_div   <= cfgDivisor;
        r_nbits <= cfgDataBits;
        r_par   <= cfgParity;
        r_stop2 <= cfgStopBits;
        r_data  <= w_fifoOutData;
      end
    end
  end

  assign txReady = w_fifoInReady;
  assign busy    = (r_state != StIdle);
  assign tx      = r_tx;

endmodule

// File: tb/tb_oclib_uart_tx_cfg.sv
// tb_oclib_uart_tx_cfg: directed bench for the configurable UART tx.
// Line waveforms are compared cycle by cycle against a frame model.
module tb_oclib_uart_tx_cfg;

  localparam int FD = 32;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic [7:0]    txData = '0;
  logic          txValid = 1'b0;
  logic          txReady;
  logic [DW-1:0] cfgDivisor = '0;
  logic [1:0]    cfgDataBits = '0;
  logic [1:0]    cfgParity = '0;
  logic          cfgStopBits = 1'b0;
  logic          breakReq = 1'b0;
  logic          busy;
  logic          tx;

  int n_chk = 0;
  int n_fail = 0;

  logic [511:0] capv;
  logic [511:0] capb;
  logic [511:0] expv;
  int explen;
  int popCnt;
  int popIdx;

  always #5 clock = ~clock;

  oclib_uart_tx_cfg #(
    .FifoDepth(FD), .DivW(DW), .ResetDivisor(868)
  ) dut (
    .clock(clock), .resetN(resetN),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .cfgDivisor(cfgDivisor), .cfgDataBits(cfgDataBits),
    .cfgParity(cfgParity), .cfgStopBits(cfgStopBits),
    .breakReq(breakReq), .busy(busy), .tx(tx)
  );

  task automatic set_cfg(input int div, input int nb,
                         input int par, input int st2);
    cfgDivisor  = DW'(div);
    cfgDataBits = 2'(nb);
    cfgParity   = 2'(par);
    cfgStopBits = 1'(st2);
  endtask

  task automatic put(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    txData  = d;
    txValid = 1'b1;
    for (int t = 0; t < 5000; t++) begin
      if (txReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (ok) begin
      @(posedge clock); #1;
    end
    txValid = 1'b0;
  endtask

  task automatic wait_start(output bit ok, output int lat,
                            input int lim);
    ok  = 1'b0;
    lat = -1;
    for (int t = 0; t < lim; t++) begin
      @(negedge clock);
      if (tx === 1'b0) begin
        ok  = 1'b1;
        lat = t;
        break;
      end
    end
  endtask

  task automatic capture(input int n);
    capv   = '0;
    capb   = '0;
    popCnt = 0;
    popIdx = -1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clock);
      capv[i] = tx;
      capb[i] = busy;
      if (dut.r_pop === 1'b1) begin
        if (popIdx < 0) popIdx = i;
        popCnt++;
      end
    end
  endtask

  task automatic exp_clear();
    expv   = '0;
    explen = 0;
  endtask

  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      expv[explen] = v;
      explen++;
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input int nb,
                           input int par, input int st2,
                           input int div);
    int n;
    bit p;
    n = nb + 5;
    p = 1'b0;
    add_level(1'b0, div);
    for (int i = 0; i < n; i++) begin
      add_level(d[i], div);
      p = p ^ d[i];
    end
    if (par == 1) add_level(p, div);
    if (par == 2) add_level(~p, div);
    if (par == 3) add_level(1'b1, div);
    add_level(1'b1, div * (st2 + 1));
  endtask

  task automatic rx_byte(input int div, output logic [7:0] d,
                         output bit ok);
    bit st;
    int lat;
    d = '0;
    wait_start(st, lat, 5000);
    ok = st;
    if (st) begin
      repeat (div / 2) @(negedge clock);
      if (tx !== 1'b0) ok = 1'b0;
      for (int b = 0; b < 8; b++) begin
        repeat (div) @(negedge clock);
        d[b] = tx;
      end
      repeat (div) @(negedge clock);
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(negedge clock);
    n_chk++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_tx got %b want 1", tx);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    n_chk++;
    if (txReady !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready got %b want 0", txReady);
    end
    @(posedge clock); #1;
    resetN = 1'b1;
    repeat (2) @(negedge clock);
    n_chk++;
    if (txReady !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready_up got %b want 1", txReady);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_quiet got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_8n1();
    bit ok;
    bit st;
    int lat;
    set_cfg(4, 3, 0, 0);
    @(posedge clock); #1;
    put(8'hA5, ok);
    wait_start(st, lat, 50);
    n_chk++;
    if (!(ok && st)) begin
      n_fail++;
      $display("FAIL a5_start got put=%b start=%b want 1 1", ok, st);
    end
    n_chk++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL a5_latency got %0d want 1", lat);
    end
    exp_clear();
    add_frame(8'hA5, 3, 0, 0, 4);
    add_level(1'b1, 4);
    capture(explen);
    n_chk++;
    if (capv !== expv) begin
      n_fail++;
      $display("FAIL a5_wave got %h want %h", capv, expv);
    end
    n_chk++;
    if (capb[39] !== 1'b1 || capb[40] !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_busy got %b%b want 10", capb[39], capb[40]);
    end
    n_chk++;
    if (popCnt !== 1 || popIdx !== 36) begin
      n_fail++;
      $display("FAIL a5_pop got %0d@%0d want 1@36", popCnt, popIdx);
    end
  endtask

  task automatic test_7e2();
    bit ok;
    bit st;
    int lat;
    set_cfg(3, 2, 1, 1);
    @(posedge clock); #1;
    put(8'h83, ok);
    wait_start(st, lat, 50);
    n_chk++;
    if (!(ok && st)) begin
      n_fail++;
      $display("FAIL 83_start got put=%b start=%b want 1 1", ok, st);
    end
    exp_clear();
    add_frame(8'h83, 2, 1, 1, 3);
    add_level(1'b1, 3);
    fork
      capture(explen);
      begin
        repeat (5) @(negedge clock); #1;
        set_cfg(7, 3, 0, 0);
      end
    join
    n_chk++;
    if (capv !== expv) begin
      n_fail++;
      $display("FAIL 83_wave got %h want %h", capv, expv);
    end
    n_chk++;
    if (capv[26:24] !== 3'b000 || capv[32:27] !== 6'h3F) begin
      n_fail++;
      $display("FAIL 83_par_stop got %b %b want 000 111111",
               capv[26:24], capv[32:27]);
    end
    n_chk++;
    if (popCnt !== 1 || popIdx !== 27) begin
      n_fail++;
      $display("FAIL 83_pop got %0d@%0d want 1@27", popCnt, popIdx);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3, st;
    int lat;
    set_cfg(2, 3, 0, 0);
    exp_clear();
    add_frame(8'h11, 3, 0, 0, 2);
    add_frame(8'hC3, 3, 0, 0, 2);
    add_frame(8'h7E, 3, 0, 0, 2);
    add_level(1'b1, 2);
    @(posedge clock); #1;
    fork
      begin
        put(8'h11, ok1);
        put(8'hC3, ok2);
        put(8'h7E, ok3);
      end
      begin
        wait_start(st, lat, 50);
        capture(explen);
      end
    join
    n_chk++;
    if (!(ok1 && ok2 && ok3 && st)) begin
      n_fail++;
      $display("FAIL b2b_start got %b%b%b%b want 1111",
               ok1, ok2, ok3, st);
    end
    n_chk++;
    if (capv !== expv) begin
      n_fail++;
      $display("FAIL b2b_wave got %h want %h", capv, expv);
    end
    n_chk++;
    if (capb[59:0] !== {60{1'b1}} || capb[60] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy got %h want 0fffffffffffffff",
               capb[60:0]);
    end
    n_chk++;
    if (popCnt !== 3) begin
      n_fail++;
      $display("FAIL b2b_pops got %0d want 3", popCnt);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] sent [FD+1];
    logic [7:0] got [FD+1];
    int nGot;
    int nPut;
    logic rdyFull;
    int bad;
    set_cfg(100, 3, 0, 0);
    for (int i = 0; i <= FD; i++) sent[i] = 8'(i * 7 + 3);
    nGot    = 0;
    nPut    = 0;
    rdyFull = 1'bx;
    @(posedge clock); #1;
    fork
      begin
        bit ok;
        for (int i = 0; i <= FD; i++) begin
          put(sent[i], ok);
          if (ok) nPut++;
          if (i == FD - 1) rdyFull = txReady;
        end
      end
      begin
        logic [7:0] d;
        bit ok;
        for (int k = 0; k <= FD; k++) begin
          rx_byte(100, d, ok);
          if (!ok) break;
          got[k] = d;
          nGot++;
        end
      end
    join
    n_chk++;
    if (rdyFull !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready got %b want 0", rdyFull);
    end
    n_chk++;
    if (nPut != FD + 1) begin
      n_fail++;
      $display("FAIL full_puts got %0d want %0d", nPut, FD + 1);
    end
    n_chk++;
    if (nGot != FD + 1) begin
      n_fail++;
      $display("FAIL full_count got %0d want %0d", nGot, FD + 1);
    end
    for (int k = 0; k < nGot; k++) begin
      n_chk++;
      if (got[k] !== sent[k]) begin
        n_fail++;
        $display("FAIL full_byte%0d got %h want %h",
                 k, got[k], sent[k]);
      end
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_extra got %0d low cycles want 0", bad);
    end
  endtask

  task automatic test_break();
    bit ok;
    bit st;
    int lat;
    set_cfg(4, 3, 0, 0);
    @(posedge clock); #1;
    put(8'h3C, ok);
    wait_start(st, lat, 50);
    n_chk++;
    if (!(ok && st)) begin
      n_fail++;
      $display("FAIL brk_start got put=%b start=%b want 1 1", ok, st);
    end
    exp_clear();
    add_frame(8'h3C, 3, 0, 0, 4);
    add_level(1'b1, 1);
    add_level(1'b0, 20);
    add_level(1'b1, 9);
    fork
      capture(explen);
      begin
        repeat (10) @(negedge clock); #1;
        breakReq = 1'b1;
        repeat (50) @(negedge clock); #1;
        breakReq = 1'b0;
      end
    join
    n_chk++;
    if (capv !== expv) begin
      n_fail++;
      $display("FAIL brk_wave got %h want %h", capv, expv);
    end
    n_chk++;
    if ({capb[40], capb[45], capb[64], capb[65]} !== 4'b0110) begin
      n_fail++;
      $display("FAIL brk_busy got %b%b%b%b want 0110",
               capb[40], capb[45], capb[64], capb[65]);
    end
    n_chk++;
    if (popCnt !== 1) begin
      n_fail++;
      $display("FAIL brk_pops got %0d want 1", popCnt);
    end
  endtask

  task automatic test_small_div();
    bit ok;
    bit st;
    int lat;
    for (int dv = 0; dv < 2; dv++) begin
      set_cfg(dv, 3, 0, 0);
      @(posedge clock); #1;
      put(dv == 0 ? 8'h55 : 8'h0F, ok);
      wait_start(st, lat, 50);
      exp_clear();
      add_frame(dv == 0 ? 8'h55 : 8'h0F, 3, 0, 0, 2);
      add_level(1'b1, 2);
      capture(explen);
      n_chk++;
      if (!(ok && st) || capv !== expv) begin
        n_fail++;
        $display("FAIL div%0d_wave got %h want %h", dv, capv, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2, st;
    int lat;
    int bad;
    set_cfg(8, 3, 0, 0);
    @(posedge clock); #1;
    put(8'h5A, ok1);
    put(8'h99, ok2);
    wait_start(st, lat, 50);
    repeat (10) @(negedge clock);
    n_chk++;
    if (!(ok1 && ok2 && st) || tx !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_pre got start=%b tx=%b want 1 0", st, tx);
    end
    #1;
    resetN = 1'b0;
    #1;
    n_chk++;
    if (tx !== 1'b1 || busy !== 1'b0 || txReady !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async got tx=%b busy=%b rdy=%b want 1 0 0",
               tx, busy, txReady);
    end
    repeat (3) @(posedge clock);
    #1;
    resetN = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rm_empty got %0d active cycles want 0", bad);
    end
    n_chk++;
    if (txReady !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_ready got %b want 1", txReady);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_back_to_back();
    test_fifo_full();
    test_break();
    test_small_div();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
